// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch stage; owns the PC and holds one instruction for decode.
// Latency: request the cycle after reset/redirect; with zero-wait memory one instruction per 3 cycles.
// Backpressure: imem_req_ready holds the request and address; instr_ready holds the instruction.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      request to instruction memory (addr is the current PC)
//   imem_rsp_valid/data            one-cycle response carrying the 32-bit instruction word
//   instr, instr_pc, instr_valid   held instruction (zero-extended) and its PC for decode
//   instr_ready                    decode accepts the held instruction
//   branch_taken, imm_branch       sampled on accept; taken selects instr_pc + imm_branch
//   flush, flush_pc                redirect, overrides everything else
//   fetch_misaligned               stalled on a target with bits [1:0] != 0
module instr_fetch #(
  parameter int unsigned     xlen         = 64,
  parameter logic [xlen-1:0] reset_vector = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [xlen-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [xlen-1:0] instr,
  output logic [xlen-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [xlen-1:0] imm_branch,
  input  logic            flush,
  input  logic [xlen-1:0] flush_pc,
  output logic            fetch_misaligned
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, FAULT} state_t;

  localparam logic [xlen-1:0] seq_step = xlen'(4);

  state_t          state;
  logic [xlen-1:0] pc;
  logic [xlen-1:0] next_pc;
  logic            flush_bad;
  logic            rsp_owed;

  // Branch target arithmetic wraps naturally at xlen bits.
  assign next_pc   = instr_pc + (branch_taken ? imm_branch : seq_step);
  assign flush_bad = (flush_pc[1:0] != 2'b00);

  // A redirect that leaves a response still owed by memory must drain it
  // before issuing again, otherwise the stale word would be taken as the new one.
  assign rsp_owed  = ((state == REQ) && imem_req_ready) ||
                     (((state == WAIT) || (state == DRAIN)) && !imem_rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= reset_vector;
      instr    <= '0;
      instr_pc <= '0;
    end else if (flush) begin
      pc <= flush_pc;
      // A misaligned redirect abandons any owed response; memory tolerates that.
      if (flush_bad)     state <= FAULT;
      else if (rsp_owed) state <= DRAIN;
      else               state <= REQ;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr    <= {{(xlen-32){1'b0}}, imem_rsp_data};
            instr_pc <= pc;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc    <= next_pc;
            state <= (next_pc[1:0] != 2'b00) ? FAULT : REQ;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) state <= REQ;
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req_valid   = (state == REQ);
  assign imem_addr        = pc;
  assign instr_valid      = (state == HOLD);
  assign fetch_misaligned = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios then randomized traffic against a flag-based fetch model.
// Memory responder with programmable readiness and latency; decode/flush driven from the bench.
// Every cycle the model's expected outputs are compared with the design.
module tb_instr_fetch;

  localparam logic [63:0] RV = 64'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [63:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] imm_branch = '0;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = '0;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  instr_fetch #(.xlen(64), .reset_vector(RV)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .imm_branch(imm_branch),
    .flush(flush), .flush_pc(flush_pc), .fetch_misaligned(fetch_misaligned)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: intent flags instead of a state number.
  //   m_idle  : first cycle out of reset, nothing offered yet
  //   m_issue : a request for m_pc is being offered
  //   m_out   : memory owes one response; m_keep says whether it is wanted
  //   m_held  : an instruction is being presented to decode
  //   m_fault : parked on a misaligned target until redirected
  logic [63:0] m_pc, m_instr, m_ipc;
  bit m_idle, m_issue, m_out, m_keep, m_held, m_fault;

  always @(posedge clk) begin : model
    logic [63:0] nxt;
    bit lost;
    if (rst) begin
      m_pc = RV; m_instr = '0; m_ipc = '0;
      m_idle = 1; m_issue = 0; m_out = 0; m_keep = 0; m_held = 0; m_fault = 0;
    end else if (flush) begin
      lost = m_out ? !imem_rsp_valid : (m_issue && imem_req_ready);
      m_pc = flush_pc;
      m_idle = 0; m_held = 0; m_fault = 0; m_issue = 0; m_out = 0; m_keep = 0;
      if (flush_pc[1:0] != 2'b00) m_fault = 1;
      else if (lost)              m_out = 1;
      else                        m_issue = 1;
    end else if (m_idle) begin
      m_idle = 0; m_issue = 1;
    end else if (m_issue) begin
      if (imem_req_ready) begin m_issue = 0; m_out = 1; m_keep = 1; end
    end else if (m_out) begin
      if (imem_rsp_valid) begin
        m_out = 0;
        if (m_keep) begin
          m_held = 1; m_instr = {32'h0, imem_rsp_data}; m_ipc = m_pc;
        end else begin
          m_issue = 1;
        end
      end
    end else if (m_held && instr_ready) begin
      nxt = m_ipc + (branch_taken ? imm_branch : 64'd4);
      m_held = 0; m_pc = nxt;
      if (nxt[1:0] != 2'b00) m_fault = 1;
      else                   m_issue = 1;
    end
  end

  always @(posedge clk) begin : compare
    #2;
    chk("req_valid", {63'h0, imem_req_valid}, {63'h0, m_issue});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {63'h0, instr_valid}, {63'h0, m_held});
    chk("fetch_misaligned", {63'h0, fetch_misaligned}, {63'h0, m_fault});
    if (m_held) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
  end

  // Instruction memory responder.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  int          rdy_pct = 100;
  int          lat_fix = 0;
  bit          dir_mode = 1;
  logic [31:0] dir_data = 32'h00000013;
  bit          spur_en = 0;

  function automatic logic [31:0] hash(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13;
  endfunction

  task automatic mem_drive();
    imem_rsp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = dir_mode ? dir_data : hash(mem_addr);
        mem_pend = 0;
      end else begin
        mem_cnt--;
      end
    end else if (spur_en && !m_out && !imem_req_valid && $urandom_range(7) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (imem_req_valid && imem_req_ready) begin
      mem_pend = 1;
      mem_addr = imem_addr;
      mem_cnt  = (lat_fix < 0) ? int'($urandom_range(2)) : lat_fix;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mem_drive();
  endtask

  task automatic do_reset();
    instr_ready = 0; flush = 0; branch_taken = 0;
    rst = 1; mem_pend = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic wait_hold(input logic [63:0] exp_pc, input string name, output int n);
    n = 0;
    while (!instr_valid && n < 30) begin
      step();
      n++;
    end
    chk({name, "_valid"}, {63'h0, instr_valid}, 64'h1);
    chk({name, "_pc"}, instr_pc, exp_pc);
  endtask

  task automatic accept(input logic [63:0] imm, input bit taken);
    imm_branch = imm; branch_taken = taken; instr_ready = 1;
    step();
    instr_ready = 0; branch_taken = 0;
  endtask

  initial begin
    int n;
    bit seen;

    // Reset state.
    step(); step();
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_addr", imem_addr, 64'h100);
    chk("rst_instr", instr, 64'h0);
    chk("rst_instr_pc", instr_pc, 64'h0);
    chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_misaligned", {63'h0, fetch_misaligned}, 64'h0);

    // Sequential fetch, zero-wait memory, decode always ready.
    rst = 0; instr_ready = 1;
    step();
    chk("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("first_req_addr", imem_addr, 64'h100);
    wait_hold(64'h100, "seq0", n);
    for (int k = 1; k <= 2; k++) begin
      step();
      chk("seq_addr", imem_addr, 64'h100 + 64'(4 * k));
      chk("seq_valid_drop", {63'h0, instr_valid}, 64'h0);
      wait_hold(64'h100 + 64'(4 * k), "seq", n);
      chk("seq_gap", 64'(n), 64'd2);
    end

    // Taken branch, forward.
    dir_data = 32'h02208463;
    do_reset();
    wait_hold(64'h100, "br40", n);
    chk("br40_instr", instr, 64'h0000_0000_0220_8463);
    accept(64'd40, 1);
    chk("br40_target", imem_addr, 64'h128);
    chk("br40_req", {63'h0, imem_req_valid}, 64'h1);

    // Taken branch, backward.
    dir_data = 32'hfe628ce3;
    do_reset();
    wait_hold(64'h100, "brm8", n);
    chk("brm8_instr", instr, 64'h0000_0000_fe62_8ce3);
    accept(64'hFFFF_FFFF_FFFF_FFF8, 1);
    chk("brm8_target", imem_addr, 64'hF8);

    // Backward branch from PC 0 wraps.
    do_reset();
    flush = 1; flush_pc = 64'h0;
    step();
    flush = 0;
    chk("wrap_req_addr", imem_addr, 64'h0);
    wait_hold(64'h0, "wrap", n);
    accept(64'hFFFF_FFFF_FFFF_FFF8, 1);
    chk("wrap_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);

    // Misaligned target parks the stage until redirected.
    do_reset();
    wait_hold(64'h100, "mis", n);
    accept(64'd2, 1);
    chk("mis_flag", {63'h0, fetch_misaligned}, 64'h1);
    chk("mis_no_req", {63'h0, imem_req_valid}, 64'h0);
    step(); step(); step();
    chk("mis_flag_held", {63'h0, fetch_misaligned}, 64'h1);
    chk("mis_no_req_held", {63'h0, imem_req_valid}, 64'h0);
    flush = 1; flush_pc = 64'h200;
    step();
    flush = 0;
    chk("mis_flush_req", {63'h0, imem_req_valid}, 64'h1);
    chk("mis_flush_addr", imem_addr, 64'h200);
    chk("mis_flush_clear", {63'h0, fetch_misaligned}, 64'h0);

    // Flush while waiting on a slow response.
    lat_fix = 2;
    do_reset();
    step();
    step();
    flush = 1; flush_pc = 64'h400;
    step();
    flush = 0;
    seen = 0; n = 0;
    while (!imem_req_valid && n < 20) begin
      seen |= instr_valid;
      step();
      n++;
    end
    chk("wflush_stale_valid", {63'h0, seen}, 64'h0);
    chk("wflush_req", {63'h0, imem_req_valid}, 64'h1);
    chk("wflush_addr", imem_addr, 64'h400);

    // Flush in the same cycle as the response.
    lat_fix = 0;
    do_reset();
    step();
    step();
    flush = 1; flush_pc = 64'h500;
    step();
    flush = 0;
    chk("sflush_req", {63'h0, imem_req_valid}, 64'h1);
    chk("sflush_addr", imem_addr, 64'h500);
    chk("sflush_no_valid", {63'h0, instr_valid}, 64'h0);

    // Reset while a response is outstanding.
    lat_fix = 2;
    dir_data = 32'hAAAA0013;
    do_reset();
    wait_hold(64'h100, "rstw", n);
    instr_ready = 1;
    step();
    instr_ready = 0;
    step();
    rst = 1;
    #1;
    chk("rstw_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rstw_addr", imem_addr, 64'h100);
    chk("rstw_instr", instr, 64'h0);
    chk("rstw_instr_pc", instr_pc, 64'h0);
    chk("rstw_instr_valid", {63'h0, instr_valid}, 64'h0);
    step();
    rst = 0;
    step();
    chk("rstw_restart_req", {63'h0, imem_req_valid}, 64'h1);
    chk("rstw_restart_addr", imem_addr, 64'h100);
    wait_hold(64'h100, "rstw_refetch", n);

    // Randomized traffic.
    dir_mode = 0; lat_fix = -1; rdy_pct = 75; spur_en = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) begin
        rst = 0;
      end else if ($urandom_range(299) == 0) begin
        rst = 1;
        mem_pend = 0;
      end
      flush = m_fault ? ($urandom_range(3) == 0) : ($urandom_range(24) == 0);
      flush_pc = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(5) == 0) flush_pc = flush_pc | 64'($urandom_range(3, 1));
      instr_ready = $urandom_range(1);
      branch_taken = $urandom_range(1);
      case ($urandom_range(9))
        0:       imm_branch = {$urandom, $urandom};
        1:       imm_branch = ((64'($urandom_range(64)) - 64'd32) << 2) + 64'd2;
        default: imm_branch = (64'($urandom_range(64)) - 64'd32) << 2;
      endcase
    end
    rst = 0; flush = 0; instr_ready = 0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
